// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low cathode patterns,
// the sampled-line bundle and the capture FSM encoding.
package ssd_pkg;

  localparam logic [6:0] SSD_PAT_0 = 7'b0000001;
  localparam logic [6:0] SSD_PAT_1 = 7'b1001111;
  localparam logic [6:0] SSD_PAT_2 = 7'b0010010;
  localparam logic [6:0] SSD_PAT_3 = 7'b0000110;
  localparam logic [6:0] SSD_PAT_4 = 7'b1001100;
  localparam logic [6:0] SSD_PAT_5 = 7'b0100100;
  localparam logic [6:0] SSD_PAT_6 = 7'b0100000;
  localparam logic [6:0] SSD_PAT_7 = 7'b0001111;
  localparam logic [6:0] SSD_PAT_8 = 7'b0000000;
  localparam logic [6:0] SSD_PAT_9 = 7'b0001100;
  localparam logic [6:0] SSD_PAT_A = 7'b0001000;
  localparam logic [6:0] SSD_PAT_B = 7'b1100000;
  localparam logic [6:0] SSD_PAT_C = 7'b0110001;
  localparam logic [6:0] SSD_PAT_D = 7'b1000010;
  localparam logic [6:0] SSD_PAT_E = 7'b0110000;
  localparam logic [6:0] SSD_PAT_F = 7'b0111000;
  localparam logic [6:0] SSD_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] cath;
    logic       dp;
  } ssd_lines_t;

  // Lines as seen with the display dark; used as the synchronizer reset value.
  localparam ssd_lines_t SSD_LINES_IDLE = '{an: 4'hF, cath: SSD_BLANK, dp: 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } ssd_state_e;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational cathode-pattern decoder: active-low 7-segment code -> {hit, hex value}.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] cath_i,
  output logic       hit_o,
  output logic [3:0] val_o
);

  always_comb begin
    hit_o = 1'b1;
    val_o = 4'h0;
    case (cath_i)
      SSD_PAT_0: val_o = 4'h0;
      SSD_PAT_1: val_o = 4'h1;
      SSD_PAT_2: val_o = 4'h2;
      SSD_PAT_3: val_o = 4'h3;
      SSD_PAT_4: val_o = 4'h4;
      SSD_PAT_5: val_o = 4'h5;
      SSD_PAT_6: val_o = 4'h6;
      SSD_PAT_7: val_o = 4'h7;
      SSD_PAT_8: val_o = 4'h8;
      SSD_PAT_9: val_o = 4'h9;
      SSD_PAT_A: val_o = 4'hA;
      SSD_PAT_B: val_o = 4'hB;
      SSD_PAT_C: val_o = 4'hC;
      SSD_PAT_D: val_o = 4'hD;
      SSD_PAT_E: val_o = 4'hE;
      SSD_PAT_F: val_o = 4'hF;
      default:   hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Rebuilds the four hex digits shown on a scanned 4-digit seven-segment display.
// Optional saturating error counter enabled by defining SSD_DECODE_ERRCNT_EN.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 2097152
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic [3:0]  An_in,
  input  logic [6:0]  Cath_in,
  input  logic        Dp_in,
  output logic [15:0] Digits,
  output logic [3:0]  DigitVld,
  output logic [3:0]  DpOut,
  output logic        frame_done,
  output logic        err,
  output logic [7:0]  ErrCnt
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  ssd_lines_t  lines_in_c;
  ssd_lines_t  sync1_q, sync_q, prev_q;
  logic [SW-1:0] stab_q;
  logic [TW-1:0] tmo_q;
  ssd_state_e  state_q;
  logic [15:0] digit_q;
  logic [15:0] digits_q;
  logic [3:0]  vld_q, dp_q, mask_q;
  logic        frame_q, err_q;

  logic        changed_c, all_high_c, one_hot_c, capture_c, eval_ok_c, eval_bad_c, timeout_c;
  logic [3:0]  low_c;
  logic [1:0]  idx_c;
  logic        pat_hit_c;
  logic [3:0]  pat_val_c;

  assign lines_in_c = '{an: An_in, cath: Cath_in, dp: Dp_in};

  ssd_pattern_decode u_decode (
    .cath_i (sync_q.cath),
    .hit_o  (pat_hit_c),
    .val_o  (pat_val_c)
  );

  // Capture qualification from the synchronized lines.
  always_comb begin
    low_c      = ~sync_q.an;
    changed_c  = (sync_q != prev_q);
    all_high_c = (sync_q.an == 4'hF);
    one_hot_c  = (low_c != 4'h0) && ((low_c & (low_c - 4'd1)) == 4'h0);
    idx_c      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (low_c[i]) idx_c = 2'(i);
    end
    capture_c  = (state_q == ST_SETTLE) && !all_high_c && !changed_c &&
                 (stab_q == SW'(STABLE_CYCLES));
    eval_ok_c  = capture_c && one_hot_c && pat_hit_c;
    eval_bad_c = capture_c && !(one_hot_c && pat_hit_c);
    timeout_c  = !eval_ok_c && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      sync1_q  <= SSD_LINES_IDLE;
      sync_q   <= SSD_LINES_IDLE;
      prev_q   <= SSD_LINES_IDLE;
      stab_q   <= '0;
      tmo_q    <= '0;
      state_q  <= ST_IDLE;
      digit_q  <= 16'h0;
      digits_q <= 16'h0;
      vld_q    <= 4'h0;
      dp_q     <= 4'h0;
      mask_q   <= 4'h0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q <= lines_in_c;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;

      if (changed_c) begin
        stab_q <= '0;
      end else if (stab_q != SW'(STABLE_CYCLES)) begin
        stab_q <= stab_q + SW'(1);
      end

      err_q   <= eval_bad_c;
      frame_q <= (mask_q == 4'hF);

      case (state_q)
        ST_IDLE:   if (!all_high_c) state_q <= ST_SETTLE;
        ST_SETTLE: begin
          if (all_high_c)     state_q <= ST_IDLE;
          else if (capture_c) state_q <= ST_HOLD;
        end
        ST_HOLD:   if (changed_c) state_q <= all_high_c ? ST_IDLE : ST_SETTLE;
        default:   state_q <= ST_IDLE;
      endcase

      // A completed mask publishes the frame; a capture in the same cycle starts the next one.
      if (mask_q == 4'hF) begin
        digits_q <= digit_q;
        mask_q   <= 4'h0;
      end

      if (eval_ok_c) begin
        digit_q[{idx_c, 2'b00} +: 4] <= pat_val_c;
        vld_q[idx_c]  <= 1'b1;
        dp_q[idx_c]   <= ~sync_q.dp;
        mask_q[idx_c] <= 1'b1;
      end else if (eval_bad_c) begin
        vld_q <= vld_q & sync_q.an;
      end

      if (eval_ok_c) begin
        tmo_q <= '0;
      end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
        tmo_q <= tmo_q + TW'(1);
      end

      if (timeout_c) begin
        vld_q   <= 4'h0;
        mask_q  <= 4'h0;
        state_q <= ST_IDLE;
      end
    end
  end

  assign Digits     = digits_q;
  assign DigitVld   = vld_q;
  assign DpOut      = dp_q;
  assign frame_done = frame_q;
  assign err        = err_q;

`ifdef SSD_DECODE_ERRCNT_EN
  logic [7:0] errcnt_q;

  always_ff @(posedge board_clk) begin
    if (reset) begin
      errcnt_q <= 8'h00;
    end else if (eval_bad_c && (errcnt_q != 8'hFF)) begin
      errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign ErrCnt = errcnt_q;
`else
  assign ErrCnt = 8'h00;
`endif

endmodule
